keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter DWELL, default 1000, clock cycles each column is driven before its rows are sampled (minimum 4).
REQ-002 Parameter STABLE_SCANS, default 4, consecutive identical full-scan results required to accept a result (minimum 1).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 row  input  4  keypad row lines, active-low, externally pulled up.
REQ-006 col  output  4  keypad column drive, active-low, exactly one bit low at any time.
REQ-007 KEY  output  4  hex code of the last accepted key, in the same code space the display decoder consumes.
REQ-008 key_valid  output  1  one-cycle strobe on acceptance of a new key code.
REQ-009 key_held  output  1  level, high while an accepted key is pressed.

Function
REQ-010 The block SHALL scan columns 0,1,2,3,0,... with col = 1110, 1101, 1011, 0111 respectively, each column driven for exactly DWELL cycles, giving a full scan of 4*DWELL cycles.
REQ-011 Rows SHALL be sampled on the last cycle of each column's dwell; col advances on the following cycle.
REQ-012 Key map (row r, col c) SHALL be: r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: 0,F,E,D.
REQ-013 A full-scan result SHALL be NONE when no row is low in any column, CODE(k) when exactly one row/column intersection is low, and NONE when two or more intersections are low (multi-key press rejected).
REQ-014 The result SHALL be evaluated on the column-3 sample cycle; a stability counter increments when the result equals the previous scan's result, else reloads to 1.
REQ-015 A result SHALL be accepted when the counter reaches STABLE_SCANS; the counter saturates and does not re-accept the same result.
REQ-016 Accepting CODE(k) that differs from the current accepted state (NONE or another code) SHALL, on the next cycle, set KEY=k, set key_held=1 and pulse key_valid for exactly one cycle.
REQ-017 Accepting NONE SHALL clear key_held on the next cycle, hold KEY unchanged and produce no strobe.
REQ-018 A direct change from accepted code a to accepted code b SHALL produce a new strobe with KEY=b and key_held remaining 1.
REQ-019 Latency from the first fully stable scan to the strobe SHALL be STABLE_SCANS full scans plus one cycle.

Reset
REQ-020 While rst is high: col=1110, KEY=0, key_valid=0, key_held=0, dwell counter=0, stability counter=0, previous result=NONE, accepted state=NONE.
REQ-021 Reset asserted mid-scan SHALL abort the scan immediately; after release, scanning restarts at column 0 and any held key requires a full STABLE_SCANS to be re-accepted (one new strobe).

Configuration
REQ-022 With KEYPAD_SYNC_EN defined, row SHALL pass through a two-flop synchronizer (reset to 1111) before sampling; the sample point is unchanged and adds no extra scan latency beyond the settle time.
REQ-023 Without KEYPAD_SYNC_EN, row SHALL be sampled directly; all other behaviour is identical.

Verification (DWELL=4, STABLE_SCANS=2; full scan = 16 cycles)
REQ-024 Assert rst mid-run, rows=1111 -> col=1110, KEY=0, key_valid=0, key_held=0 immediately, with no clock edge required.
REQ-025 Press '5' (row1 low while col=1101) continuously -> exactly one key_valid pulse within 3 full scans (48 cycles), KEY=5, key_held=1, no further pulses.
REQ-026 Release '5' -> key_held=0 within 3 scans, KEY stays 5, no pulse.
REQ-027 Press '1' and '2' simultaneously -> no pulse, key_held=0; then release '2' -> one pulse with KEY=1.
REQ-028 Press 'D' for one scan only, then release -> no pulse; then hold '7' then switch directly to '9' -> two pulses, KEY=7 then KEY=9, key_held stays 1.
REQ-029 Hold 'A', assert rst for 3 cycles mid-column-2 -> outputs cleared and col=1110; after release, a single new pulse with KEY=A; run with and without KEYPAD_SYNC_EN.

Source files
------------

// File: rtl/keypad_scan_if.sv
// Keypad matrix signal bundle: rows in, column drive and key results out.
// The scanner takes the master modport, the keypad/consumer side the slave modport.
interface keypad_scan_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] KEY;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  row,
        output col,
        output KEY,
        output key_valid,
        output key_held
    );

    modport slave (
        output row,
        input  col,
        input  KEY,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner with whole-scan debounce and multi-key rejection.
// Define KEYPAD_SYNC_EN to route the row inputs through a two-flop synchronizer.
module keypad_scan #(
    parameter int DWELL        = 1000,
    parameter int STABLE_SCANS = 4
) (
    input logic           clk,
    input logic           rst,
    keypad_scan_if.master kp
);

    localparam int DW = $clog2(DWELL);
    localparam int SW = $clog2(STABLE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [SW-1:0] STABLE_N   = SW'(STABLE_SCANS);
    // bit 4 marks a single-key code; all-zero means no key
    localparam logic [4:0] RES_NONE = 5'd0;

    typedef enum logic [1:0] {COL0, COL1, COL2, COL3} col_e;

    col_e          col_q, col_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    hits_q, hits_d;
    logic [3:0]    code_q, code_d;
    logic [4:0]    prev_q, prev_d;
    logic [4:0]    acc_q, acc_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [3:0]    key_q, key_d;
    logic          valid_q, valid_d;
    logic          held_q, held_d;
    logic [3:0]    row_s;

`ifdef KEYPAD_SYNC_EN
    logic [3:0] sync1_q, sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= kp.row;
            sync2_q <= sync1_q;
        end
    end

    assign row_s = sync2_q;
`else
    assign row_s = kp.row;
`endif

    function automatic logic [3:0] key_code(logic [1:0] r, logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'b0000: k = 4'h1;
            4'b0001: k = 4'h2;
            4'b0010: k = 4'h3;
            4'b0011: k = 4'hA;
            4'b0100: k = 4'h4;
            4'b0101: k = 4'h5;
            4'b0110: k = 4'h6;
            4'b0111: k = 4'hB;
            4'b1000: k = 4'h7;
            4'b1001: k = 4'h8;
            4'b1010: k = 4'h9;
            4'b1011: k = 4'hC;
            4'b1100: k = 4'h0;
            4'b1101: k = 4'hF;
            4'b1110: k = 4'hE;
            default: k = 4'hD;
        endcase
        return k;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= COL0;
            dwell_q <= '0;
            hits_q  <= '0;
            code_q  <= '0;
            prev_q  <= RES_NONE;
            acc_q   <= RES_NONE;
            stab_q  <= '0;
            key_q   <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            dwell_q <= dwell_d;
            hits_q  <= hits_d;
            code_q  <= code_d;
            prev_q  <= prev_d;
            acc_q   <= acc_d;
            stab_q  <= stab_d;
            key_q   <= key_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    logic [3:0]    hit;
    logic [2:0]    n_hit;
    logic [2:0]    tot;
    logic [1:0]    r_idx;
    logic [1:0]    base_hits;
    logic [3:0]    base_code;
    logic [4:0]    res;
    logic          same;
    logic [SW-1:0] stab_n;
    logic          sample;

    always_comb begin
        col_d     = col_q;
        dwell_d   = dwell_q + DW'(1);
        hits_d    = hits_q;
        code_d    = code_q;
        prev_d    = prev_q;
        acc_d     = acc_q;
        stab_d    = stab_q;
        key_d     = key_q;
        valid_d   = 1'b0;
        held_d    = held_q;
        res       = RES_NONE;
        same      = 1'b0;
        stab_n    = stab_q;
        r_idx     = 2'd0;
        hit       = ~row_s;
        n_hit     = 3'(hit[0]) + 3'(hit[1]) + 3'(hit[2]) + 3'(hit[3]);
        sample    = (dwell_q == DWELL_LAST);
        base_hits = (col_q == COL0) ? 2'd0 : hits_q;
        base_code = (col_q == COL0) ? 4'd0 : code_q;
        tot       = 3'(base_hits) + n_hit;

        for (int i = 3; i >= 0; i--) begin
            if (hit[i]) r_idx = 2'(i);
        end

        if (sample) begin
            dwell_d = '0;
            unique case (col_q)
                COL0: col_d = COL1;
                COL1: col_d = COL2;
                COL2: col_d = COL3;
                COL3: col_d = COL0;
            endcase
            // hit count saturates at 2: anything above one key is rejected
            hits_d = (tot >= 3'd2) ? 2'd2 : tot[1:0];
            code_d = (n_hit == 3'd1) ? key_code(r_idx, col_q) : base_code;

            if (col_q == COL3) begin
                res    = (hits_d == 2'd1) ? {1'b1, code_d} : RES_NONE;
                same   = (res == prev_q);
                if (!same) stab_n = SW'(1);
                else if (stab_q != STABLE_N) stab_n = stab_q + SW'(1);
                prev_d = res;
                stab_d = stab_n;
                if (stab_n == STABLE_N && !(same && stab_q == STABLE_N)) begin
                    acc_d = res;
                    if (!res[4]) begin
                        held_d = 1'b0;
                    end else if (res != acc_q) begin
                        key_d   = res[3:0];
                        valid_d = 1'b1;
                        held_d  = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        unique case (col_q)
            COL0: kp.col = 4'b1110;
            COL1: kp.col = 4'b1101;
            COL2: kp.col = 4'b1011;
            COL3: kp.col = 4'b0111;
        endcase
    end

    assign kp.KEY       = key_q;
    assign kp.key_valid = valid_q;
    assign kp.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan: directed key presses, expected strobes queued
// and checked by an independent monitor on the falling clock edge.
module tb_keypad_scan;

    localparam int DWELL = 4;
    localparam int STABLE = 2;
    localparam int SCAN = 4 * DWELL;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] pressed = '0;  // bit r*4+c
    int checks = 0;
    int fails = 0;
    logic [3:0] exp_q[$];

    keypad_scan_if kif ();

    keypad_scan #(.DWELL(DWELL), .STABLE_SCANS(STABLE)) dut (
        .clk(clk),
        .rst(rst),
        .kp (kif)
    );

    always #5 clk = ~clk;

    // keypad matrix: a pressed switch pulls its row low while its column is driven low
    always_comb begin
        kif.row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !kif.col[c]) kif.row[r] = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_scans(input int n);
        repeat (n * SCAN) @(negedge clk);
    endtask

    function automatic logic [15:0] k(input int r, input int c);
        logic [15:0] m;
        m = '0;
        m[r*4+c] = 1'b1;
        return m;
    endfunction

    always @(negedge clk) begin
        if (!rst && kif.key_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_strobe: KEY=%0h with no strobe expected", kif.KEY);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (kif.KEY !== e || kif.key_held !== 1'b1) begin
                    fails++;
                    $display("FAIL strobe: KEY=%0h held=%0b expected KEY=%0h held=1",
                             kif.KEY, kif.key_held, e);
                end
            end
        end
    end

    initial begin
        bit found;
        repeat (5) @(negedge clk);
        chk("rst_col", kif.col, 4'b1110);
        chk("rst_key", kif.KEY, 4'h0);
        chk("rst_valid", kif.key_valid, 1'b0);
        chk("rst_held", kif.key_held, 1'b0);
        rst = 1'b0;

        wait_scans(3);
        chk("idle_held", kif.key_held, 1'b0);

        pressed = k(1, 1);
        exp_q.push_back(4'h5);
        wait_scans(4);
        chk("p5_drained", exp_q.size(), 0);
        chk("p5_key", kif.KEY, 4'h5);
        chk("p5_held", kif.key_held, 1'b1);
        wait_scans(3);

        pressed = '0;
        wait_scans(4);
        chk("r5_held", kif.key_held, 1'b0);
        chk("r5_key", kif.KEY, 4'h5);

        pressed = k(0, 0) | k(0, 1);
        wait_scans(4);
        chk("multi_held", kif.key_held, 1'b0);
        chk("multi_key", kif.KEY, 4'h5);
        pressed = k(0, 0);
        exp_q.push_back(4'h1);
        wait_scans(4);
        chk("p1_drained", exp_q.size(), 0);
        chk("p1_key", kif.KEY, 4'h1);
        chk("p1_held", kif.key_held, 1'b1);

        pressed = '0;
        wait_scans(4);
        pressed = k(3, 3);
        repeat (SCAN) @(negedge clk);
        pressed = '0;
        wait_scans(4);
        chk("glitch_key", kif.KEY, 4'h1);
        chk("glitch_held", kif.key_held, 1'b0);

        pressed = k(2, 0);
        exp_q.push_back(4'h7);
        wait_scans(4);
        chk("p7_drained", exp_q.size(), 0);
        chk("p7_key", kif.KEY, 4'h7);
        pressed = k(2, 2);
        exp_q.push_back(4'h9);
        wait_scans(4);
        chk("p9_drained", exp_q.size(), 0);
        chk("p9_key", kif.KEY, 4'h9);
        chk("p9_held", kif.key_held, 1'b1);

        pressed = '0;
        wait_scans(4);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_col", kif.col, 4'b1110);
        chk("mrst_key", kif.KEY, 4'h0);
        chk("mrst_valid", kif.key_valid, 1'b0);
        chk("mrst_held", kif.key_held, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        pressed = k(0, 3);
        exp_q.push_back(4'hA);
        wait_scans(4);
        chk("pA_key", kif.KEY, 4'hA);
        chk("pA_held", kif.key_held, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 4 * SCAN && !found; i++) begin
            @(negedge clk);
            if (kif.col == 4'b1011) found = 1'b1;
        end
        chk("col2_seen", found, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_col", kif.col, 4'b1110);
        chk("arst_key", kif.KEY, 4'h0);
        chk("arst_held", kif.key_held, 1'b0);
        repeat (3) @(negedge clk);
        exp_q.push_back(4'hA);
        rst = 1'b0;
        wait_scans(4);
        chk("pA2_drained", exp_q.size(), 0);
        chk("pA2_key", kif.KEY, 4'hA);
        chk("pA2_held", kif.key_held, 1'b1);
        wait_scans(2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
